// File: rtl/emif_seq_pkg.sv
// rtl/emif_seq_pkg.sv - shared state encoding, defaults and sizing helpers for the EMIF calibration sequencer
package emif_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_RST_EMIF = 3'd2,
        ST_CAL_WAIT = 3'd3,
        ST_RUN      = 3'd4,
        ST_ERROR    = 3'd5
    } state_t;

    localparam int DEF_SETTLE_CYCLES = 1024;
    localparam int DEF_RESET_PULSE   = 64;
    localparam int DEF_CAL_TIMEOUT   = 1048576;
    localparam int DEF_MAX_RETRIES   = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The counters only ever need to reach (limit - 1), so $clog2(limit) bits suffice.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for one asynchronous level input
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/emif_cal_sequencer.sv
// rtl/emif_cal_sequencer.sv - EMIF power-up, calibration retry and recalibration sequencer
module emif_cal_sequencer
    import emif_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int RESET_PULSE   = DEF_RESET_PULSE,
    parameter int CAL_TIMEOUT   = DEF_CAL_TIMEOUT,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       cal_success,
    input  logic       cal_fail,
    input  logic       restart_req,
    output logic       emif_reset_n,
    output logic       user_reset_n,
    output logic       cal_done,
    output logic       cal_error,
    output logic [2:0] state,
    output logic [1:0] retry_cnt
);
    localparam int CNT_W = cnt_width(max3(SETTLE_CYCLES, RESET_PULSE, CAL_TIMEOUT));
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RESET_PULSE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CAL_TIMEOUT - 1);

    logic locked_s;
    logic success_s;
    logic fail_s;

    sync_2ff u_sync_lock    (.clk(clk), .reset_n(reset_n), .d(pll_locked),  .q(locked_s));
    sync_2ff u_sync_success (.clk(clk), .reset_n(reset_n), .d(cal_success), .q(success_s));
    sync_2ff u_sync_fail    (.clk(clk), .reset_n(reset_n), .d(cal_fail),    .q(fail_s));

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       retry_nxt;
    logic             attempt_failed;

    always_comb begin
        nxt_state      = cur_state;
        retry_nxt      = retry_cnt;
        attempt_failed = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                if (locked_s) nxt_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!locked_s)                nxt_state = ST_IDLE;
                else if (cnt == SETTLE_LAST) nxt_state = ST_RST_EMIF;
            end
            ST_RST_EMIF: begin
                if (cnt == PULSE_LAST) nxt_state = ST_CAL_WAIT;
            end
            ST_CAL_WAIT: begin
                // A failure report outranks a simultaneous success report.
                if (fail_s)                     attempt_failed = 1'b1;
                else if (success_s)             nxt_state      = ST_RUN;
                else if (cnt == TIMEOUT_LAST)   attempt_failed = 1'b1;
                if (attempt_failed) begin
                    retry_nxt = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
                    nxt_state = (int'(retry_cnt) < MAX_RETRIES) ? ST_RST_EMIF : ST_ERROR;
                end
            end
            ST_RUN: begin
                if (!locked_s || !success_s) begin
                    nxt_state = ST_IDLE;
                end else if (restart_req) begin
                    nxt_state = ST_RST_EMIF;
                    retry_nxt = 2'd0;
                end
            end
            ST_ERROR: begin
                if (restart_req) begin
                    nxt_state = ST_RST_EMIF;
                    retry_nxt = 2'd0;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
        if (nxt_state == ST_IDLE) retry_nxt = 2'd0;
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state    <= ST_IDLE;
            retry_cnt    <= 2'd0;
            emif_reset_n <= 1'b0;
            user_reset_n <= 1'b0;
            cal_done     <= 1'b0;
            cal_error    <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            retry_cnt    <= retry_nxt;
            emif_reset_n <= (nxt_state == ST_CAL_WAIT) || (nxt_state == ST_RUN);
            user_reset_n <= (nxt_state == ST_RUN);
            cal_done     <= (nxt_state == ST_RUN);
            cal_error    <= (nxt_state == ST_ERROR);
        end
    end

    // Cleared on every state change, so it never needs to wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (nxt_state != cur_state) begin
            cnt <= '0;
        end else if (cur_state == ST_SETTLE || cur_state == ST_RST_EMIF ||
                     cur_state == ST_CAL_WAIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign state = cur_state;

endmodule
